// File: rtl/fft_sm_seq_ctrl.sv
// Sequencer for a radix-2 FFT: bit-reversed load of the sample LUT into working
// memory, then issues every butterfly of every stage over a valid/ready handshake.
module fft_sm_seq_ctrl #(
  parameter int LOG2N  = 8,
  parameter int LUT_AW = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [LUT_AW-1:0] lut_n,
  input  logic [DATA_W-1:0] lut_x_re,
  output logic              mem_we,
  output logic [LOG2N-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [LOG2N-1:0]  bf_a_addr,
  output logic [LOG2N-1:0]  bf_b_addr,
  output logic [LOG2N-2:0]  bf_tw_idx,
  output logic [3:0]        bf_stage,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

  state_t           state_reg, state_next;
  logic [LOG2N:0]   k_reg, k_next;
  logic [3:0]       s_reg, s_next;
  logic [LOG2N-2:0] j_reg, j_next;

  logic             mem_we_reg, bf_valid_reg, busy_reg, done_reg;
  logic [LOG2N-1:0] bf_a_reg, bf_b_reg;
  logic [LOG2N-2:0] bf_tw_reg;
  logic [3:0]       bf_stage_reg;

  logic [LOG2N-1:0] k_rev;
  logic [LOG2N-1:0] j_ext, pos_mask, pos_v, grp_v, a_v, b_v;
  logic [LOG2N-2:0] tw_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      s_reg     <= '0;
      j_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      s_reg     <= s_next;
      j_reg     <= j_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    s_next     = s_reg;
    j_next     = j_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          k_next     = '0;
        end
      end
      LOAD: begin
        k_next = k_reg + 1'b1;
        if (&k_reg[LOG2N-1:0]) begin
          state_next = COMPUTE;
          k_next     = '0;
          s_next     = '0;
          j_next     = '0;
        end
      end
      COMPUTE: begin
        if (bf_ready) begin
          if (&j_reg) begin
            j_next = '0;
            if (s_reg == 4'(LOG2N-1)) state_next = DONE;
            else                      s_next     = s_reg + 1'b1;
          end else begin
            j_next = j_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Butterfly addressing for the upcoming (s, j) so the bf_* outputs can be registered.
  always_comb begin
    j_ext    = {1'b0, j_next};
    pos_mask = ~({LOG2N{1'b1}} << s_next);
    pos_v    = j_ext & pos_mask;
    grp_v    = j_ext >> s_next;
    a_v      = ((grp_v << s_next) << 1) | pos_v;
    b_v      = a_v + ({{(LOG2N-1){1'b0}}, 1'b1} << s_next);
    tw_v     = (LOG2N-1)'(pos_v << (4'(LOG2N-1) - s_next));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_reg   <= 1'b0;
      bf_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bf_a_reg     <= '0;
      bf_b_reg     <= '0;
      bf_tw_reg    <= '0;
      bf_stage_reg <= '0;
    end else begin
      mem_we_reg   <= (state_next == LOAD);
      bf_valid_reg <= (state_next == COMPUTE);
      busy_reg     <= (state_next == LOAD) || (state_next == COMPUTE);
      done_reg     <= (state_next == DONE);
      if (state_next == COMPUTE) begin
        bf_a_reg     <= a_v;
        bf_b_reg     <= b_v;
        bf_tw_reg    <= tw_v;
        bf_stage_reg <= s_next;
      end else begin
        bf_a_reg     <= '0;
        bf_b_reg     <= '0;
        bf_tw_reg    <= '0;
        bf_stage_reg <= '0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
      assign k_rev[gi] = k_reg[LOG2N-1-gi];
    end
  endgenerate

  // mem_we_reg mirrors state LOAD, so it also gates the LOAD-only outputs to zero elsewhere.
  assign lut_n     = mem_we_reg ? LUT_AW'(k_reg) : '0;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_we_reg ? k_rev : '0;
  assign mem_wdata = mem_we_reg ? lut_x_re : '0;
  assign bf_valid  = bf_valid_reg;
  assign bf_a_addr = bf_a_reg;
  assign bf_b_addr = bf_b_reg;
  assign bf_tw_idx = bf_tw_reg;
  assign bf_stage  = bf_stage_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_fft_sm_seq_ctrl.sv
// Scoreboard bench for fft_sm_seq_ctrl: expected LUT writes and butterflies are queued
// at stimulus time and popped by a monitor as the DUT presents them.
module tb_fft_sm_seq_ctrl;
  localparam int LOG2N = 8, LUT_AW = 10, DATA_W = 32, N = 256, NBF = 1024;

  logic clk = 1'b0;
  logic rst, start, bf_ready;
  logic [LUT_AW-1:0] lut_n;
  logic [DATA_W-1:0] lut_x_re, mem_wdata;
  logic mem_we, bf_valid, busy, done;
  logic [LOG2N-1:0] mem_addr, bf_a_addr, bf_b_addr;
  logic [LOG2N-2:0] bf_tw_idx;
  logic [3:0] bf_stage;

  always #5 clk = ~clk;

  fft_sm_seq_ctrl #(.LOG2N(LOG2N), .LUT_AW(LUT_AW), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .lut_n(lut_n), .lut_x_re(lut_x_re),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_a_addr(bf_a_addr),
    .bf_b_addr(bf_b_addr), .bf_tw_idx(bf_tw_idx), .bf_stage(bf_stage),
    .busy(busy), .done(done)
  );

  function automatic logic [31:0] lut_val(input logic [LUT_AW-1:0] n);
    case (n)
      10'd1:   return 32'd18;
      10'd2:   return 32'hFFFFFFE0;
      10'd255: return 32'd6;
      default: return {n[7:0], 8'hA5, ~n[7:0], 8'h3C};
    endcase
  endfunction
  assign lut_x_re = lut_val(lut_n);

  typedef struct packed { logic [9:0] n; logic [7:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [7:0] a; logic [7:0] b; logic [6:0] tw; logic [3:0] st; } bf_t;

  wr_t  wr_q[$];
  bf_t  bf_q[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   acc_cnt = 0, last_acc_cyc = 0;
  logic rand_ready = 1'b0;
  logic [9:0]  cap_lutn[N];
  logic [7:0]  cap_addr[N];
  logic [31:0] cap_data[N];
  bf_t         cap_bf[NBF];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bitrev8(input int v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic push_transform();
    wr_t w;
    bf_t b;
    int half, base;
    for (int k = 0; k < N; k++) begin
      w.n = 10'(k); w.addr = bitrev8(k); w.data = lut_val(10'(k));
      wr_q.push_back(w);
    end
    for (int st = 0; st < LOG2N; st++) begin
      half = 1 << st;
      for (int g = 0; g < (128 >> st); g++)
        for (int p = 0; p < half; p++) begin
          base = g * 2 * half + p;
          b.a = 8'(base); b.b = 8'(base + half); b.tw = 7'(p * (128 >> st)); b.st = 4'(st);
          bf_q.push_back(b);
        end
    end
  endtask

  task automatic clear_caps();
    for (int i = 0; i < N; i++) begin cap_lutn[i] = '1; cap_addr[i] = '1; cap_data[i] = '1; end
    for (int i = 0; i < NBF; i++) cap_bf[i] = '1;
  endtask

  task automatic spot_checks();
    check("k1_lut_n",    96'(cap_lutn[1]), 96'd1);
    check("k1_addr",     96'(cap_addr[1]), 96'd128);
    check("k1_wdata",    96'(cap_data[1]), 96'd18);
    check("k2_addr",     96'(cap_addr[2]), 96'd64);
    check("k2_wdata",    96'(cap_data[2]), 96'hFFFFFFE0);
    check("k255_addr",   96'(cap_addr[255]), 96'd255);
    check("k255_wdata",  96'(cap_data[255]), 96'd6);
    check("bf_s0_j0",    96'(cap_bf[0]),    96'({8'd0, 8'd1, 7'd0, 4'd0}));
    check("bf_s1_j1",    96'(cap_bf[129]),  96'({8'd1, 8'd3, 7'd64, 4'd1}));
    check("bf_s7_j127",  96'(cap_bf[1023]), 96'({8'd127, 8'd255, 7'd127, 4'd7}));
  endtask

  function automatic logic [95:0] all_outs();
    return 96'({lut_n, mem_we, mem_addr, mem_wdata, bf_valid, bf_a_addr, bf_b_addr,
                bf_tw_idx, bf_stage, busy, done});
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    bf_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Monitor: pops expectations as writes and handshakes appear, checks hold-while-stalled.
  initial begin
    wr_t  e;
    bf_t  eb, cur, prev;
    logic stall_prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        cur = {bf_a_addr, bf_b_addr, bf_tw_idx, bf_stage};
        if (mem_we) begin
          if (wr_q.size() == 0) check("unexpected_mem_write", 96'(mem_addr), 96'hDEAD);
          else begin
            e = wr_q.pop_front();
            check("load_lut_n", 96'(lut_n), 96'(e.n));
            check("load_addr",  96'(mem_addr), 96'(e.addr));
            check("load_wdata", 96'(mem_wdata), 96'(e.data));
            cap_lutn[e.n[7:0]] = lut_n;
            cap_addr[e.n[7:0]] = mem_addr;
            cap_data[e.n[7:0]] = mem_wdata;
          end
        end
        if (bf_valid && stall_prev) check("bf_hold_when_stalled", 96'(cur), 96'(prev));
        if (bf_valid && bf_ready) begin
          if (bf_q.size() == 0) check("unexpected_bf_accept", 96'(cur), 96'hDEAD);
          else begin
            eb = bf_q.pop_front();
            check("bf_request", 96'(cur), 96'(eb));
            if (acc_cnt < NBF) cap_bf[acc_cnt] = cur;
          end
          acc_cnt++;
          last_acc_cyc = cyc;
        end
        stall_prev = bf_valid && !bf_ready;
        prev = cur;
        if (done) begin
          check("done_after_last_accept", 96'(cyc), 96'(last_acc_cyc + 1));
          check("accepts_per_transform", 96'(acc_cnt), 96'(NBF));
          check("done_cycle_quiet", 96'({busy, bf_valid, mem_we}), 96'd0);
          acc_cnt = 0;
        end
      end
    end
  end

  // One start pulse; measures busy span and done cycle relative to the sampling edge.
  task automatic run_one(input bit fixed_timing);
    int n, first_busy, last_busy, busy_cnt, done_cyc, done_cnt;
    bit seen;
    first_busy = -1; last_busy = -1; busy_cnt = 0; done_cyc = -1; done_cnt = 0; seen = 0; n = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!seen && n < 8000) begin
      @(negedge clk);
      n++;
      if (busy) begin
        if (first_busy < 0) first_busy = n;
        last_busy = n;
        busy_cnt++;
      end
      if (done) begin done_cyc = n; done_cnt++; seen = 1; end
    end
    if (!seen) check("done_timeout", 96'd0, 96'd1);
    @(negedge clk);
    check("done_single_pulse", 96'({done, busy}), 96'd0);
    check("first_busy_cycle", 96'(first_busy), 96'd1);
    check("busy_contiguous", 96'(busy_cnt), 96'(last_busy - first_busy + 1));
    check("done_follows_busy", 96'(done_cyc), 96'(last_busy + 1));
    if (fixed_timing) begin
      check("busy_cycle_count", 96'(busy_cnt), 96'd1280);
      check("done_cycle", 96'(done_cyc), 96'd1281);
    end
  endtask

  initial begin
    int n, d1, d2, b2, busy_after;
    rst = 1'b1; start = 1'b0; bf_ready = 1'b1;
    clear_caps();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 96'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Scenario 1: reset in the middle of LOAD.
    push_transform();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(mem_we && lut_n == 10'd100) && n < 400) begin @(negedge clk); n++; end
    check("reached_k100", 96'(lut_n), 96'd100);
    #1 rst = 1'b1;
    #1 check("reset_mid_load_outputs", all_outs(), 96'd0);
    wr_q.delete(); bf_q.delete(); acc_cnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", all_outs(), 96'd0);

    // Scenarios 2-4: full transform, ready tied high.
    clear_caps();
    push_transform();
    run_one(1'b1);
    spot_checks();

    // Scenario 5: ~30% ready duty.
    clear_caps();
    rand_ready = 1'b1;
    push_transform();
    run_one(1'b0);
    spot_checks();
    rand_ready = 1'b0;

    // Scenario 6: start held high across two transforms.
    push_transform();
    push_transform();
    @(posedge clk); #1 start = 1'b1;
    d1 = -1; d2 = -1; b2 = -1; n = 0;
    while (d2 < 0 && n < 6000) begin
      @(negedge clk);
      n++;
      if (d1 >= 0 && b2 < 0 && busy) b2 = n;
      if (done) begin
        if (d1 < 0) d1 = n;
        else begin d2 = n; start = 1'b0; end
      end
    end
    check("held_start_second_done", 96'(d2 > 0), 96'd1);
    check("held_start_one_idle_gap", 96'(b2), 96'(d1 + 2));
    check("held_start_transform_len", 96'(d2 - d1), 96'd1282);
    busy_after = 0;
    repeat (6) begin @(negedge clk); if (busy) busy_after++; end
    check("no_transform_after_release", 96'(busy_after), 96'd0);
    check("write_queue_drained", 96'(wr_q.size()), 96'd0);
    check("bf_queue_drained", 96'(bf_q.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
